// File: rtl/decode_scoreboard.sv
// Decode-stage register scoreboard: tracks pending writebacks, gates issue on RAW/WAW hazards and
// inflight capacity, and supports drain and flush. Optional stall counter enabled by STALL_COUNT_EN.
module decode_scoreboard #(
  parameter int REG_COUNT      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_INFLIGHT   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dec_valid,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs2,
  input  logic                      dec_uses_rs1,
  input  logic                      dec_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rd,
  input  logic                      dec_writes_rd,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      flush,
  input  logic                      drain_req,
  output logic                      dec_ready,
  output logic                      issue,
  output logic [REG_COUNT-1:0]      pending,
  output logic [2:0]                inflight,
  output logic                      drain_done,
  output logic                      wb_err
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [REG_COUNT-1:0]   pending_q, pending_d;
  logic [2:0]             inflight_q, inflight_d;
  logic                   wb_err_q, wb_err_d;

  logic src1_haz, src2_haz, waw_haz;
  logic wb_clr, wb_bad, rd_set, has_room;

  // Register 0 and indices beyond REG_COUNT are never pending.
  function automatic logic is_pend(input logic [REG_ADDR_WIDTH-1:0] idx,
                                   input logic [REG_COUNT-1:0]      vec);
    logic res;
    res = 1'b0;
    if (idx != '0 && int'(idx) < REG_COUNT) res = vec[idx];
    return res;
  endfunction

  // Handshake: the decode stage holds dec_valid and its fields stable; an instruction is
  // accepted (issue) in any cycle where dec_valid and dec_ready are both 1. dec_ready is
  // combinational and never depends on dec_valid.
  always_comb begin
    src1_haz  = dec_uses_rs1 && is_pend(dec_rs1, pending_q) && !(wb_valid && wb_rd == dec_rs1);
    src2_haz  = dec_uses_rs2 && is_pend(dec_rs2, pending_q) && !(wb_valid && wb_rd == dec_rs2);
    waw_haz   = dec_writes_rd && is_pend(dec_rd, pending_q) && !(wb_valid && wb_rd == dec_rd);
    wb_clr    = wb_valid && is_pend(wb_rd, pending_q);
    wb_bad    = wb_valid && (wb_rd != '0) && !wb_clr;
    has_room  = inflight_q < 3'(MAX_INFLIGHT);
    dec_ready = (state_q == RUN) && !flush && !src1_haz && !src2_haz && !waw_haz &&
                (!dec_writes_rd || has_room || wb_clr);
    issue     = dec_valid && dec_ready;
    rd_set    = issue && dec_writes_rd && (dec_rd != '0) && (int'(dec_rd) < REG_COUNT);
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    inflight_d = inflight_q;
    wb_err_d   = wb_err_q | wb_bad;
    drain_done = 1'b0;

    // Clear before set so a same-cycle issue to the retiring register keeps it pending.
    if (wb_clr) pending_d[wb_rd] = 1'b0;
    if (rd_set) pending_d[dec_rd] = 1'b1;

    case ({rd_set, wb_clr})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      RUN: begin
        if (drain_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (inflight_q == 3'd0) begin
          state_d    = RUN;
          drain_done = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (flush) begin
      state_d    = RUN;
      pending_d  = '0;
      inflight_d = 3'd0;
      drain_done = (state_q == DRAIN);
    end

    if (reset) drain_done = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pending_q  <= '0;
      inflight_q <= 3'd0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign pending  = pending_q;
  assign inflight = inflight_q;
  assign wb_err   = wb_err_q;

`ifdef STALL_COUNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (dec_valid && !dec_ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= 32'd0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard: expectations are queued while driving each cycle and
// popped against DUT outputs sampled 1ns after the falling edge.
module tb_decode_scoreboard;

  localparam int W = 32;

  logic        clk;
  logic        reset;
  logic        dec_valid;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic        dec_uses_rs1, dec_uses_rs2, dec_writes_rd;
  logic        wb_valid, flush, drain_req;
  logic        dec_ready, issue, drain_done, wb_err;
  logic [31:0] pending;
  logic [2:0]  inflight;
`ifdef STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  decode_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .dec_valid     (dec_valid),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .dec_uses_rs1  (dec_uses_rs1),
    .dec_uses_rs2  (dec_uses_rs2),
    .dec_rd        (dec_rd),
    .dec_writes_rd (dec_writes_rd),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .flush         (flush),
    .drain_req     (drain_req),
    .dec_ready     (dec_ready),
    .issue         (issue),
    .pending       (pending),
    .inflight      (inflight),
    .drain_done    (drain_done),
    .wb_err        (wb_err)
`ifdef STALL_COUNT_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] bm(input int r);
    return 32'h1 << r;
  endfunction

  // driver tasks
  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_uses_rs1 = 0; dec_uses_rs2 = 0;
    dec_rd = 0; dec_writes_rd = 0; wb_valid = 0; wb_rd = 0; flush = 0; drain_req = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic issue_w(input logic [4:0] rd);
    dec_valid = 1; dec_writes_rd = 1; dec_rd = rd;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid = 1; wb_rd = rd;
  endtask

  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic settle();
    #1;
  endtask

  // scoreboard compare
  task automatic chk(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: obs=%0h exp=<queue empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: obs=%0h exp=%0h", tag, obs, e);
      end
    end
  endtask

  initial begin
    reset = 1;
    idle();
    repeat (3) @(negedge clk);
    push(0); settle(); chk("drain_done_in_reset", 32'(drain_done));

    // reset state
    @(negedge clk);
    reset = 0; idle();
    push(0); push(0); push(0); push(0); push(1);
    settle();
    chk("rst_pending", pending); chk("rst_inflight", 32'(inflight));
    chk("rst_wb_err", 32'(wb_err)); chk("rst_drain_done", 32'(drain_done));
    chk("rst_ready", 32'(dec_ready));
`ifdef STALL_COUNT_EN
    push(0); chk("rst_stall", stall_cycles);
`endif

    // register 0: writeback and issue have no effect
    tick(); wb(0);
    tick(); issue_w(0); push(0); push(1); push(1);
    settle(); chk("wb0_err", 32'(wb_err)); chk("rd0_ready", 32'(dec_ready)); chk("rd0_issue", 32'(issue));
    tick(); push(0); push(0);
    settle(); chk("rd0_pending", pending); chk("rd0_inflight", 32'(inflight));

    // RAW on rs1 held until matching writeback
    tick(); issue_w(5); push(1); push(1);
    settle(); chk("raw_issue_ready", 32'(dec_ready)); chk("raw_issue", 32'(issue));
    tick(); dec_valid = 1; dec_uses_rs1 = 1; dec_rs1 = 5;
    push(bm(5)); push(1); push(0); push(0);
    settle(); chk("raw_pending", pending); chk("raw_inflight", 32'(inflight));
    chk("raw_ready", 32'(dec_ready)); chk("raw_noissue", 32'(issue));
    for (int i = 0; i < 2; i++) begin
      tick(); dec_valid = 1; dec_uses_rs1 = 1; dec_rs1 = 5; push(0);
      settle(); chk("raw_hold", 32'(dec_ready));
    end
    tick(); dec_valid = 1; dec_uses_rs1 = 1; dec_rs1 = 5; wb(5); push(1); push(1);
    settle(); chk("raw_bypass_ready", 32'(dec_ready)); chk("raw_bypass_issue", 32'(issue));
    tick(); push(0); push(0);
    settle(); chk("raw_clr_pending", pending); chk("raw_clr_inflight", 32'(inflight));

    // RAW on rs2, ignored when uses_rs2 is low
    tick(); issue_w(8);
    tick(); dec_valid = 1; dec_uses_rs2 = 1; dec_rs2 = 8; push(0);
    settle(); chk("rs2_haz", 32'(dec_ready));
    tick(); dec_valid = 1; dec_rs2 = 8; push(1);
    settle(); chk("rs2_unused", 32'(dec_ready));
    tick(); wb(8);

    // WAW, then same-cycle set/clear keeps register pending
    tick(); issue_w(7); push(bm(8) & 32'h0); push(0);
    settle(); chk("waw_pre_pending", pending); chk("waw_pre_inflight", 32'(inflight));
    tick(); issue_w(7); push(0);
    settle(); chk("waw_haz", 32'(dec_ready));
    tick(); issue_w(7); wb(7); push(1); push(1);
    settle(); chk("waw_bypass_ready", 32'(dec_ready)); chk("waw_bypass_issue", 32'(issue));
    tick(); push(bm(7)); push(1);
    settle(); chk("setwins_pending", pending); chk("setwins_inflight", 32'(inflight));
    tick(); wb(7);
    tick(); push(0); push(0);
    settle(); chk("waw_clr_pending", pending); chk("waw_clr_inflight", 32'(inflight));

    // capacity limit
    for (int r = 1; r <= 4; r++) begin
      tick(); issue_w(5'(r)); push(1);
      settle(); chk("fill_ready", 32'(dec_ready));
    end
    tick(); issue_w(6); push(4); push(bm(1) | bm(2) | bm(3) | bm(4)); push(0);
    settle(); chk("full_inflight", 32'(inflight)); chk("full_pending", pending);
    chk("full_stall", 32'(dec_ready));
    tick(); issue_w(6); wb(1); push(1); push(1);
    settle(); chk("full_wb_ready", 32'(dec_ready)); chk("full_wb_issue", 32'(issue));
    tick(); push(4); push(bm(2) | bm(3) | bm(4) | bm(6));
    settle(); chk("swap_inflight", 32'(inflight)); chk("swap_pending", pending);
    tick(); wb(2);
    tick(); wb(3);
    tick(); wb(4); push(2);
    settle(); chk("retire_inflight", 32'(inflight));
    tick(); wb(6);
    tick(); push(0); push(0); push(0);
    settle(); chk("empty_inflight", 32'(inflight)); chk("empty_pending", pending);
    chk("no_err_yet", 32'(wb_err));

    // drain
    tick(); issue_w(3);
    tick(); issue_w(7);
    tick(); drain_req = 1; push(1); push(0);
    settle(); chk("drainreq_ready", 32'(dec_ready)); chk("drainreq_done", 32'(drain_done));
    tick(); dec_valid = 1; push(0); push(0); push(0);
    settle(); chk("drain_ready", 32'(dec_ready)); chk("drain_noissue", 32'(issue));
    chk("drain_done_early", 32'(drain_done));
    tick(); dec_valid = 1; wb(3); push(0); push(0);
    settle(); chk("drain_wb3_ready", 32'(dec_ready)); chk("drain_wb3_done", 32'(drain_done));
    tick(); dec_valid = 1; wb(7); push(0);
    settle(); chk("drain_wb7_done", 32'(drain_done));
    tick(); dec_valid = 1; push(0); push(1); push(0);
    settle(); chk("drain_inflight0", 32'(inflight)); chk("drain_done_pulse", 32'(drain_done));
    chk("drain_exit_ready", 32'(dec_ready));
    tick(); dec_valid = 1; push(0); push(1); push(1);
    settle(); chk("drain_done_off", 32'(drain_done)); chk("run_ready", 32'(dec_ready));
    chk("run_issue", 32'(issue));

    // flush in RUN
    tick(); issue_w(2);
    tick(); issue_w(9);
    tick(); flush = 1; dec_valid = 1;
    push(0); push(0); push(0); push(2); push(bm(2) | bm(9));
    settle(); chk("flush_ready", 32'(dec_ready)); chk("flush_issue", 32'(issue));
    chk("flush_run_done", 32'(drain_done)); chk("flush_pre_inflight", 32'(inflight));
    chk("flush_pre_pending", pending);
    tick(); push(0); push(0); push(1);
    settle(); chk("flush_pending", pending); chk("flush_inflight", 32'(inflight));
    chk("flush_ready_after", 32'(dec_ready));

    // flush in DRAIN pulses drain_done
    tick(); issue_w(4);
    tick(); drain_req = 1;
    tick(); push(0); push(0);
    settle(); chk("drain2_ready", 32'(dec_ready)); chk("drain2_done", 32'(drain_done));
    tick(); flush = 1; push(1);
    settle(); chk("flush_drain_done", 32'(drain_done));
    tick(); push(0); push(1); push(0);
    settle(); chk("flush_drain_off", 32'(drain_done)); chk("flush_drain_run", 32'(dec_ready));
    chk("flush_drain_inflight", 32'(inflight));

    // sticky wb_err
    tick(); wb(12);
    tick(); push(1); push(0); push(0);
    settle(); chk("wberr_set", 32'(wb_err)); chk("wberr_pending", pending);
    chk("wberr_inflight", 32'(inflight));
    repeat (3) tick();
    tick(); wb(0);
    tick(); push(1);
    settle(); chk("wberr_sticky", 32'(wb_err));

    // reset overrides an in-progress drain
    tick(); issue_w(5);
    tick(); drain_req = 1;
    tick(); wb(5);
    tick(); reset = 1; push(0);
    settle(); chk("rst_drain_done", 32'(drain_done));
    tick(); reset = 0; push(0); push(0); push(0); push(1); push(0);
    settle(); chk("rst2_wb_err", 32'(wb_err)); chk("rst2_inflight", 32'(inflight));
    chk("rst2_pending", pending); chk("rst2_ready", 32'(dec_ready));
    chk("rst2_drain_done", 32'(drain_done));

`ifdef STALL_COUNT_EN
    tick(); issue_w(5);
    for (int i = 0; i < 10; i++) begin
      tick(); dec_valid = 1; dec_uses_rs1 = 1; dec_rs1 = 5;
    end
    tick(); push(10);
    settle(); chk("stall_count", stall_cycles);
    tick(); wb(5);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_scoreboard.md
DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 SHALL have parameter REG_COUNT, default 32, number of architectural registers.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, register index width.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4, maximum outstanding register-writing instructions (1..7).
REQ-004 SHALL have ports, one per line:
  clk  input  1  single clock, all state updates on rising edge
  reset  input  1  synchronous, active-high reset
  dec_valid  input  1  decode stage presents an instruction
  dec_rs1  input  REG_ADDR_WIDTH  source register 1 index
  dec_rs2  input  REG_ADDR_WIDTH  source register 2 index
  dec_uses_rs1  input  1  instruction reads rs1
  dec_uses_rs2  input  1  instruction reads rs2
  dec_rd  input  REG_ADDR_WIDTH  destination register index
  dec_writes_rd  input  1  instruction writes rd
  wb_valid  input  1  register-file write this cycle (same strobe as regfile wr_en)
  wb_rd  input  REG_ADDR_WIDTH  register being written
  flush  input  1  discard all in-flight instructions
  drain_req  input  1  request pipeline drain
  dec_ready  output  1  instruction may issue this cycle
  issue  output  1  dec_valid and dec_ready
  pending  output  REG_COUNT  bitmap of registers awaiting writeback
  inflight  output  3  outstanding writing instructions
  drain_done  output  1  one-cycle pulse, drain complete
  wb_err  output  1  sticky: writeback to non-pending register
  stall_cycles  output  32  stall counter (only with STALL_COUNT_EN)

Function
REQ-005 State machine SHALL have states RUN and DRAIN; reset state RUN.
REQ-006 RUN -> DRAIN when drain_req=1; DRAIN -> RUN on the cycle after inflight reaches 0, with drain_done=1 for exactly that transition cycle.
REQ-007 In DRAIN, dec_ready SHALL be 0.
REQ-008 A source hazard SHALL exist when a used rs is pending and not cleared by a same-cycle wb_valid with wb_rd equal to it.
REQ-009 A WAW hazard SHALL exist when dec_writes_rd=1 and dec_rd is pending and not cleared in the same cycle by a matching writeback.
REQ-010 Register 0 SHALL never be pending and never cause a hazard; issue with dec_rd=0 SHALL not change pending or inflight.
REQ-011 dec_ready SHALL be combinational: 1 only in RUN, flush=0, no source or WAW hazard, and (dec_writes_rd=0 or inflight<MAX_INFLIGHT or a valid writeback of a pending register this cycle).
REQ-012 On issue with dec_writes_rd=1 and dec_rd!=0, pending[dec_rd] SHALL be set and inflight incremented on the next edge.
REQ-013 On wb_valid with pending[wb_rd]=1, pending[wb_rd] SHALL clear and inflight decrement on the next edge.
REQ-014 Simultaneous issue-set and writeback-clear of the same register SHALL leave it pending (set wins) with inflight unchanged.
REQ-015 wb_valid to a non-pending register or to register 0 SHALL not change pending or inflight; a non-pending nonzero register SHALL set wb_err.
REQ-016 flush SHALL have priority over issue, writeback and drain: next edge pending=0, inflight=0, state=RUN; drain_done SHALL pulse if state was DRAIN.
REQ-017 inflight SHALL never exceed MAX_INFLIGHT nor go below 0.

Reset
REQ-018 On reset: state RUN, pending=0, inflight=0, wb_err=0, drain_done=0, stall_cycles=0; reset overrides all other inputs including an in-progress drain.

Configuration
REQ-019 Macro STALL_COUNT_EN defined: stall_cycles SHALL increment (saturating at 2^32-1) each cycle with dec_valid=1 and dec_ready=0, cleared by reset only.
REQ-020 Without STALL_COUNT_EN: stall_cycles port SHALL be absent and no counter logic SHALL exist.

Verification
REQ-021 Issue rd=5, next cycle dec_rs1=5 used -> dec_ready=0 until wb_valid wb_rd=5; that wb cycle dec_ready=1.
REQ-022 Issue four writers to rd=1,2,3,4 -> inflight=4; fifth writer rd=6 stalls; wb_rd=1 same cycle -> issues, inflight stays 4.
REQ-023 pending={3,7}, drain_req -> dec_ready=0; wb 3 then wb 7 -> drain_done one-cycle pulse, state RUN.
REQ-024 pending={2,9}, flush with dec_valid=1 -> dec_ready=0 that cycle; next cycle pending=0, inflight=0.
REQ-025 wb_valid wb_rd=12 with nothing pending -> wb_err=1 and stays 1 until reset; wb_rd=0 -> wb_err unchanged.
REQ-026 With STALL_COUNT_EN, hold a source hazard 10 cycles with dec_valid=1 -> stall_cycles=10.
